// File: rtl/btn_debounce_rst_if.sv
// Button conditioner bus: raw button in, conditioned level, pulses and reset out.
// o_long exists only when BTN_LONGPRESS_EN is defined.
interface btn_debounce_rst_if;
  logic i_button;
  logic o_level;
  logic o_press;
  logic o_release;
  logic o_rst;
`ifdef BTN_LONGPRESS_EN
  logic o_long;
`endif

  // Conditioner side
  modport slave (
    input  i_button,
`ifdef BTN_LONGPRESS_EN
    output o_long,
`endif
    output o_level,
    output o_press,
    output o_release,
    output o_rst
  );

  // Button source / consumer side
  modport master (
    output i_button,
`ifdef BTN_LONGPRESS_EN
    input  o_long,
`endif
    input  o_level,
    input  o_press,
    input  o_release,
    input  o_rst
  );
endinterface

// File: rtl/btn_debounce_rst.sv
// Push-button conditioner: 2-flop synchroniser, stability-counter debounce,
// press/release pulses and a stretched reset for the LED cycle stages.
// Optional macro BTN_LONGPRESS_EN adds a one-shot long-press pulse (o_long).
module btn_debounce_rst #(
  parameter int unsigned P_DEBOUNCE_CYCLES = 240000,
  parameter int unsigned P_RST_STRETCH     = 16
`ifdef BTN_LONGPRESS_EN
  ,
  parameter int unsigned P_LONG_CYCLES     = 24000000
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst,
  btn_debounce_rst_if.slave   bus
);

  localparam int unsigned W_DB = $clog2(P_DEBOUNCE_CYCLES + 1);
  localparam int unsigned W_ST = $clog2(P_RST_STRETCH + 1);
  localparam logic [W_DB-1:0] C_DB_LAST = W_DB'(P_DEBOUNCE_CYCLES - 1);
  localparam logic [W_ST-1:0] C_ST_LOAD = W_ST'(P_RST_STRETCH);

  logic            r_s1;
  logic            r_s2;
  logic [W_DB-1:0] r_db_cnt;
  logic            r_level;
  logic            r_press;
  logic            r_release;
  logic [W_ST-1:0] r_st_cnt;
  logic            r_rst;

  logic [W_DB-1:0] w_db_cnt_nxt;
  logic            w_toggle;
  logic            w_level_nxt;
  logic            w_cause;
  logic [W_ST-1:0] w_st_cnt_nxt;
  logic            w_rst_nxt;

  // Debounce next-state: count while the synchronised input disagrees, toggle on the last count
  always_comb begin
    w_toggle     = 1'b0;
    w_db_cnt_nxt = '0;
    if (r_s2 != r_level) begin
      if (r_db_cnt == C_DB_LAST) begin
        w_toggle = 1'b1;
      end else begin
        w_db_cnt_nxt = r_db_cnt + W_DB'(1);
      end
    end
    w_level_nxt = r_level ^ w_toggle;
  end

  // Stretch next-state: o_rst covers every cycle o_level is high, then P_RST_STRETCH more
  always_comb begin
    w_cause      = r_level | w_level_nxt;
    w_st_cnt_nxt = '0;
    if (w_cause) begin
      w_st_cnt_nxt = C_ST_LOAD;
    end else if (r_st_cnt != '0) begin
      w_st_cnt_nxt = r_st_cnt - W_ST'(1);
    end
    w_rst_nxt = w_cause | (w_st_cnt_nxt != '0);
  end

  // State register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_st_cnt  <= C_ST_LOAD;
      r_rst     <= 1'b1;
    end else begin
      r_s1      <= bus.i_button;
      r_s2      <= r_s1;
      r_db_cnt  <= w_db_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_toggle & ~r_level;
      r_release <= w_toggle & r_level;
      r_st_cnt  <= w_st_cnt_nxt;
      r_rst     <= w_rst_nxt;
    end
  end

  assign bus.o_level   = r_level;
  assign bus.o_press   = r_press;
  assign bus.o_release = r_release;
  assign bus.o_rst     = r_rst;

`ifdef BTN_LONGPRESS_EN
  localparam int unsigned W_LG = $clog2(P_LONG_CYCLES + 1);
  localparam logic [W_LG-1:0] C_LG_LAST = W_LG'(P_LONG_CYCLES - 1);
  localparam logic [W_LG-1:0] C_LG_SAT  = W_LG'(P_LONG_CYCLES);

  logic [W_LG-1:0] r_hold_cnt;
  logic            r_long;
  logic [W_LG-1:0] w_hold_nxt;
  logic            w_long_nxt;

  // Hold counter: parks one past the fire point so each press gives at most one pulse
  always_comb begin
    w_hold_nxt = '0;
    w_long_nxt = 1'b0;
    if (r_level) begin
      w_long_nxt = (r_hold_cnt == C_LG_LAST);
      w_hold_nxt = (r_hold_cnt == C_LG_SAT) ? r_hold_cnt : r_hold_cnt + W_LG'(1);
    end
  end

  // Long-press register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_cnt <= '0;
      r_long     <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_nxt;
      r_long     <= w_long_nxt;
    end
  end

  assign bus.o_long = r_long;
`endif

endmodule

// File: tb/tb_btn_debounce_rst.sv
// Testbench for btn_debounce_rst: per-cycle expectation table, scoreboard queue.
module tb_btn_debounce_rst;

  typedef struct {
    logic        rst;
    logic        btn;
    int unsigned n;
    logic        lvl;
    logic        prs;
    logic        rel;
    logic        ors;
    logic        lng;
  } vec_t;

  typedef struct {
    logic [4:0]  bits;
    int unsigned idx;
  } exp_t;

  logic clk;
  logic i_rst;
  int   n_cmp;
  int   n_bad;
  int   cyc;
  vec_t tbl[$];
  exp_t sb[$];

  btn_debounce_rst_if bus ();

  btn_debounce_rst #(
    .P_DEBOUNCE_CYCLES (8),
    .P_RST_STRETCH     (4)
`ifdef BTN_LONGPRESS_EN
    ,
    .P_LONG_CYCLES     (32)
`endif
  ) dut (
    .i_clk (clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic btn, input int unsigned n,
                     input logic lvl, input logic prs, input logic rel,
                     input logic ors, input logic lng);
    vec_t v;
    v.rst = rst; v.btn = btn; v.n = n;
    v.lvl = lvl; v.prs = prs; v.rel = rel; v.ors = ors; v.lng = lng;
    tbl.push_back(v);
  endtask

  // Drive one record for v.n cycles; each cycle's expectation goes to the scoreboard
  task automatic apply(input vec_t v, input int unsigned idx);
    exp_t e;
    logic lng;
`ifdef BTN_LONGPRESS_EN
    lng = v.lng;
`else
    lng = 1'b0;
`endif
    for (int k = 0; k < int'(v.n); k++) begin
      @(negedge clk);
      i_rst        = v.rst;
      bus.i_button = v.btn;
      e.bits = {v.lvl, v.prs, v.rel, v.ors, lng};
      e.idx  = idx;
      sb.push_back(e);
    end
  endtask

  // Monitor: compare outputs 1 time unit after each rising edge
  initial begin
    exp_t       e;
    logic [4:0] act;
    logic       lng;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
`ifdef BTN_LONGPRESS_EN
        lng = bus.o_long;
`else
        lng = 1'b0;
`endif
        act = {bus.o_level, bus.o_press, bus.o_release, bus.o_rst, lng};
        n_cmp++;
        if (act !== e.bits) begin
          n_bad++;
          $display("FAIL vec%0d cyc=%0d lvl/prs/rel/rst/long got %b required %b",
                   e.idx, cyc, act, e.bits);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    i_rst = 1'b1;
    bus.i_button = 1'b0;

    // Reset held, then o_rst falls 4 cycles after release
    add(1,0,3, 0,0,0,1,0);
    add(0,0,3, 0,0,0,1,0);
    add(0,0,3, 0,0,0,0,0);
    // Press: level on edge 10 with one press pulse, o_rst with it
    add(0,1,9, 0,0,0,0,0);
    add(0,1,1, 1,1,0,1,0);
    add(0,1,5, 1,0,0,1,0);
    // Release: level falls on edge 10, release pulse, o_rst 4 cycles later
    add(0,0,9, 1,0,0,1,0);
    add(0,0,1, 0,0,1,1,0);
    add(0,0,3, 0,0,0,1,0);
    add(0,0,4, 0,0,0,0,0);
    // 5-cycle glitch is rejected
    add(0,1,5, 0,0,0,0,0);
    add(0,0,12,0,0,0,0,0);
    // Press, release, re-press 2 cycles after release; the re-press needs the
    // full debounce interval, which is longer than the stretch
    add(0,1,9, 0,0,0,0,0);
    add(0,1,1, 1,1,0,1,0);
    add(0,1,12,1,0,0,1,0);
    add(0,0,9, 1,0,0,1,0);
    add(0,0,1, 0,0,1,1,0);
    add(0,0,2, 0,0,0,1,0);
    add(0,1,1, 0,0,0,1,0);
    add(0,1,8, 0,0,0,0,0);
    add(0,1,1, 1,1,0,1,0);
    add(0,1,5, 1,0,0,1,0);
    // Release, then i_rst inside the stretch keeps o_rst high with no gap
    add(0,0,9, 1,0,0,1,0);
    add(0,0,1, 0,0,1,1,0);
    add(0,0,2, 0,0,0,1,0);
    add(1,0,1, 0,0,0,1,0);
    add(0,0,3, 0,0,0,1,0);
    add(0,0,2, 0,0,0,0,0);
    // Reset mid-count: debounce restarts from zero after reset
    add(0,1,5, 0,0,0,0,0);
    add(1,1,1, 0,0,0,1,0);
    add(0,1,3, 0,0,0,1,0);
    add(0,1,6, 0,0,0,0,0);
    add(0,1,1, 1,1,0,1,0);
    add(0,1,3, 1,0,0,1,0);
    // Reset during a pending release: level drops with no release pulse
    add(0,0,4, 1,0,0,1,0);
    add(1,0,1, 0,0,0,1,0);
    add(0,0,3, 0,0,0,1,0);
    add(0,0,3, 0,0,0,0,0);
    // Reset on the edge a press would be accepted: pulse suppressed
    add(0,1,9, 0,0,0,0,0);
    add(1,1,1, 0,0,0,1,0);
    add(0,1,3, 0,0,0,1,0);
    add(0,1,6, 0,0,0,0,0);
    add(0,1,1, 1,1,0,1,0);
    add(0,0,9, 1,0,0,1,0);
    add(0,0,1, 0,0,1,1,0);
    add(0,0,3, 0,0,0,1,0);
    add(0,0,2, 0,0,0,0,0);
`ifdef BTN_LONGPRESS_EN
    // Long hold: one o_long on cycle 32 after the level rise
    add(0,1,9, 0,0,0,0,0);
    add(0,1,1, 1,1,0,1,0);
    add(0,1,31,1,0,0,1,0);
    add(0,1,1, 1,0,0,1,1);
    add(0,1,18,1,0,0,1,0);
    add(0,0,9, 1,0,0,1,0);
    add(0,0,1, 0,0,1,1,0);
    add(0,0,3, 0,0,0,1,0);
    add(0,0,2, 0,0,0,0,0);
    // Reset mid-hold: no o_long, hold count restarts with the new rise
    add(0,1,9, 0,0,0,0,0);
    add(0,1,1, 1,1,0,1,0);
    add(0,1,20,1,0,0,1,0);
    add(1,1,1, 0,0,0,1,0);
    add(0,1,3, 0,0,0,1,0);
    add(0,1,6, 0,0,0,0,0);
    add(0,1,1, 1,1,0,1,0);
    add(0,1,30,1,0,0,1,0);
    add(0,0,9, 1,0,0,1,0);
    add(0,0,1, 0,0,1,1,0);
    add(0,0,3, 0,0,0,1,0);
    add(0,0,2, 0,0,0,0,0);
`endif

    foreach (tbl[i]) apply(tbl[i], i);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations pending, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
